// File: rtl/store_drain_unit_pkg.sv
// Shared types for the store drain unit: FSM states, widths and the bus
// write-request record used by both this unit and the core's bus master.
package store_drain_unit_pkg;

   localparam int PHYS_W  = 32;
   localparam int WAYS_N  = 4;
   localparam int WORD_AW = PHYS_W - 2;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_CHECK    = 3'd2,
      S_WRITE    = 3'd3,
      S_BUS_REQ  = 3'd4,
      S_BUS_WAIT = 3'd5,
      S_DONE     = 3'd6
   } drain_state_e;

   typedef struct packed {
      logic [WORD_AW-1:0] addr;
      logic [31:0]        data;
      logic [3:0]         bm;
      logic               io;
   } bus_wreq_t;

endpackage

// File: rtl/store_drain_unit_if.sv
// System-bus write channel between the drain unit (master) and the fabric.
interface store_drain_unit_if;
   import store_drain_unit_pkg::*;

   logic               bus_req_o;
   logic [WORD_AW-1:0] bus_addr_o;
   logic [31:0]        bus_data_o;
   logic [3:0]         bus_bm_o;
   logic               bus_io_o;
   logic               bus_gnt_i;
   logic               bus_ack_i;

   modport master (
      output bus_req_o, bus_addr_o, bus_data_o, bus_bm_o, bus_io_o,
      input  bus_gnt_i, bus_ack_i
   );

   modport slave (
      input  bus_req_o, bus_addr_o, bus_data_o, bus_bm_o, bus_io_o,
      output bus_gnt_i, bus_ack_i
   );

endinterface

// File: rtl/store_drain_unit.sv
// Drains the store buffer head: optional tag probe and cache write on a hit,
// unconditional write-through to the bus, then a one-cycle retire pulse.
module store_drain_unit
   import store_drain_unit_pkg::*;
#(
   parameter int PHYS = PHYS_W,
   parameter int WAYS = WAYS_N
) (
   input  logic                    cpu_clk_i,
   input  logic                    cpu_rst_i,
   input  logic                    store_valid_i,
   input  logic [PHYS-3:0]         store_address_i,
   input  logic [31:0]             store_data_i,
   input  logic [3:0]              store_bm_i,
   input  logic                    store_io_i,
   output logic                    cache_done,
   input  logic                    cache_busy_i,
   output logic                    probe_valid_o,
   output logic [PHYS-3:0]         probe_addr_o,
   input  logic                    probe_hit_i,
   input  logic [$clog2(WAYS)-1:0] probe_way_i,
   output logic                    dwr_en_o,
   output logic [PHYS-3:0]         dwr_addr_o,
   output logic [$clog2(WAYS)-1:0] dwr_way_o,
   output logic [31:0]             dwr_data_o,
   output logic [3:0]              dwr_bm_o,
   output logic                    drain_idle_o,
   output logic [31:0]             stores_drained_o,
   store_drain_unit_if.master      bus
);

   drain_state_e            state_q, state_d;
   bus_wreq_t               hold_q, hold_d;
   logic [$clog2(WAYS)-1:0] way_q, way_d;
   logic [31:0]             cnt_q, cnt_d;
   logic                    done_q, breq_q, idle_q, lookup_q, write_q;

   // Next-state, holding-register and counter logic
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      way_d   = way_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (store_valid_i) begin
               hold_d.addr = store_address_i;
               hold_d.data = store_data_i;
               hold_d.bm   = store_bm_i;
               hold_d.io   = store_io_i;
               state_d     = store_io_i ? S_BUS_REQ : S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOKUP: begin
            if (!cache_busy_i) state_d = S_CHECK;
            else               state_d = S_LOOKUP;
         end
         S_CHECK: begin
            if (probe_hit_i) begin
               way_d   = probe_way_i;
               state_d = S_WRITE;
            end else begin
               state_d = S_BUS_REQ;
            end
         end
         S_WRITE: begin
            if (!cache_busy_i) state_d = S_BUS_REQ;
            else               state_d = S_WRITE;
         end
         S_BUS_REQ: begin
            if (bus.bus_gnt_i) state_d = S_BUS_WAIT;
            else               state_d = S_BUS_REQ;
         end
         S_BUS_WAIT: begin
            if (bus.bus_ack_i) state_d = S_DONE;
            else               state_d = S_BUS_WAIT;
         end
         S_DONE: begin
            cnt_d   = cnt_q + 32'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, holding registers and registered state-decoded output flags
   always_ff @(posedge cpu_clk_i) begin
      if (cpu_rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 32'd0;
         done_q   <= 1'b0;
         breq_q   <= 1'b0;
         idle_q   <= 1'b1;
         lookup_q <= 1'b0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         way_q    <= way_d;
         cnt_q    <= cnt_d;
         done_q   <= (state_d == S_DONE);
         breq_q   <= (state_d == S_BUS_REQ);
         idle_q   <= (state_d == S_IDLE);
         lookup_q <= (state_d == S_LOOKUP);
         write_q  <= (state_d == S_WRITE);
      end
   end

   // The SRAM ports belong to refill whenever busy, so enables are masked in-cycle.
   assign probe_valid_o    = lookup_q & ~cache_busy_i;
   assign dwr_en_o         = write_q & ~cache_busy_i;
   assign probe_addr_o     = hold_q.addr;
   assign dwr_addr_o       = hold_q.addr;
   assign dwr_way_o        = way_q;
   assign dwr_data_o       = hold_q.data;
   assign dwr_bm_o         = hold_q.bm;
   assign cache_done       = done_q;
   assign drain_idle_o     = idle_q;
   assign stores_drained_o = cnt_q;
   assign bus.bus_req_o    = breq_q;
   assign bus.bus_addr_o   = hold_q.addr;
   assign bus.bus_data_o   = hold_q.data;
   assign bus.bus_bm_o     = hold_q.bm;
   assign bus.bus_io_o     = hold_q.io;

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit with a simple tag/bus responder model.
module tb_store_drain_unit;
   import store_drain_unit_pkg::*;

   typedef struct {
      logic        io;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  bm;
      logic        hit;
      logic [1:0]  way;
      int          gnt_d;
      int          ack_d;
      logic [15:0] busy;
      int          lat;
      int          probes;
      int          writes;
   } vec_t;

   logic        cpu_clk_i = 1'b0;
   logic        cpu_rst_i;
   logic        store_valid_i;
   logic [29:0] store_address_i;
   logic [31:0] store_data_i;
   logic [3:0]  store_bm_i;
   logic        store_io_i;
   logic        cache_done;
   logic        cache_busy_i;
   logic        probe_valid_o;
   logic [29:0] probe_addr_o;
   logic        probe_hit_i;
   logic [1:0]  probe_way_i;
   logic        dwr_en_o;
   logic [29:0] dwr_addr_o;
   logic [1:0]  dwr_way_o;
   logic [31:0] dwr_data_o;
   logic [3:0]  dwr_bm_o;
   logic        drain_idle_o;
   logic [31:0] stores_drained_o;

   store_drain_unit_if bus ();

   store_drain_unit dut (
      .cpu_clk_i        (cpu_clk_i),
      .cpu_rst_i        (cpu_rst_i),
      .store_valid_i    (store_valid_i),
      .store_address_i  (store_address_i),
      .store_data_i     (store_data_i),
      .store_bm_i       (store_bm_i),
      .store_io_i       (store_io_i),
      .cache_done       (cache_done),
      .cache_busy_i     (cache_busy_i),
      .probe_valid_o    (probe_valid_o),
      .probe_addr_o     (probe_addr_o),
      .probe_hit_i      (probe_hit_i),
      .probe_way_i      (probe_way_i),
      .dwr_en_o         (dwr_en_o),
      .dwr_addr_o       (dwr_addr_o),
      .dwr_way_o        (dwr_way_o),
      .dwr_data_o       (dwr_data_o),
      .dwr_bm_o         (dwr_bm_o),
      .drain_idle_o     (drain_idle_o),
      .stores_drained_o (stores_drained_o),
      .bus              (bus.master)
   );

   always #5 cpu_clk_i = ~cpu_clk_i;

   int n_chk = 0, n_pass = 0;
   vec_t vecs[5];
   vec_t ent[4];
   int n_ent, head, cyc;
   logic [15:0] run_busy;
   logic prev_pv, waiting;
   int req_cnt, wait_cnt;
   int n_probe, n_wr, n_gnt, n_done, bad_bus, bad_dwr, bad_probe, idle_busy;
   logic [29:0] gnt_addr[4];
   int done_cyc[4];
   int cnt_exp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic load(input int i);
      store_valid_i   = 1'b1;
      store_address_i = ent[i].addr;
      store_data_i    = ent[i].data;
      store_bm_i      = ent[i].bm;
      store_io_i      = ent[i].io;
   endtask

   task automatic start(input int n);
      n_ent = n; head = 0; cyc = 0;
      run_busy = ent[0].busy;
      prev_pv = 1'b0; waiting = 1'b0; req_cnt = 0; wait_cnt = 0;
      n_probe = 0; n_wr = 0; n_gnt = 0; n_done = 0;
      bad_bus = 0; bad_dwr = 0; bad_probe = 0; idle_busy = 0;
      for (int k = 0; k < 4; k++) begin gnt_addr[k] = 30'd0; done_cyc[k] = -1; end
      load(0);
   endtask

   // Drive responder inputs for this cycle, sample outputs, then move to the next negedge.
   task automatic step();
      int h;
      h = (head < n_ent) ? head : n_ent - 1;
      cache_busy_i = (cyc < 16) ? run_busy[cyc[3:0]] : 1'b0;
      probe_hit_i  = prev_pv ? ent[h].hit : ~ent[h].hit;
      probe_way_i  = prev_pv ? ent[h].way : ~ent[h].way;
      bus.bus_gnt_i = bus.bus_req_o && !waiting && (req_cnt == ent[h].gnt_d);
      bus.bus_ack_i = waiting && (wait_cnt == ent[h].ack_d);
      assert (!(bus.bus_gnt_i && bus.bus_ack_i));
      #1;
      if (probe_valid_o) begin
         n_probe++;
         if (probe_addr_o !== ent[h].addr) bad_probe++;
      end
      if (dwr_en_o) begin
         n_wr++;
         if (dwr_addr_o !== ent[h].addr || dwr_data_o !== ent[h].data ||
             dwr_bm_o !== ent[h].bm || dwr_way_o !== ent[h].way) bad_dwr++;
      end
      if (bus.bus_req_o) begin
         if (bus.bus_addr_o !== ent[h].addr || bus.bus_data_o !== ent[h].data ||
             bus.bus_bm_o !== ent[h].bm || bus.bus_io_o !== ent[h].io) bad_bus++;
      end
      if (bus.bus_gnt_i) begin
         if (n_gnt < 4) gnt_addr[n_gnt] = bus.bus_addr_o;
         n_gnt++;
      end
      if (drain_idle_o && cyc > 0 && n_done == 0) idle_busy++;
      if (cache_done) begin
         if (n_done < 4) done_cyc[n_done] = cyc;
         n_done++;
         head++;
         if (head < n_ent) load(head);
         else store_valid_i = 1'b0;
      end
      prev_pv = probe_valid_o;
      if (bus.bus_gnt_i) begin waiting = 1'b1; wait_cnt = 0; req_cnt = 0; end
      else if (bus.bus_req_o) req_cnt++;
      else req_cnt = 0;
      if (bus.bus_ack_i) begin waiting = 1'b0; wait_cnt = 0; end
      else if (waiting && !bus.bus_gnt_i) wait_cnt++;
      cyc++;
      @(negedge cpu_clk_i);
   endtask

   task automatic run(input int n);
      start(n);
      while (n_done < n && cyc < 60) step();
      chk("done_pulses", n_done, n);
   endtask

   initial begin
      cpu_rst_i = 1'b1; store_valid_i = 1'b0; store_address_i = 30'd0;
      store_data_i = 32'd0; store_bm_i = 4'd0; store_io_i = 1'b0;
      cache_busy_i = 1'b0; probe_hit_i = 1'b0; probe_way_i = 2'd0;
      bus.bus_gnt_i = 1'b0; bus.bus_ack_i = 1'b0;

      //             io    addr          data           bm    hit   way gnt ack busy     lat pr wr
      vecs[0] = '{1'b1, 30'h0400_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'd0, 0, 0, 16'h0000, 3, 0, 0};
      vecs[1] = '{1'b0, 30'h0000_1234, 32'h1122_3344, 4'h3, 1'b1, 2'd2, 0, 0, 16'h0000, 6, 1, 1};
      vecs[2] = '{1'b0, 30'h0000_2000, 32'hA5A5_5A5A, 4'hC, 1'b0, 2'd1, 0, 0, 16'h0000, 5, 1, 0};
      vecs[3] = '{1'b0, 30'h0001_0F00, 32'h0BAD_F00D, 4'h6, 1'b1, 2'd1, 0, 0, 16'h00CE, 11, 1, 1};
      vecs[4] = '{1'b0, 30'h2AAA_5555, 32'hCAFE_0001, 4'h9, 1'b1, 2'd3, 4, 2, 16'h0000, 12, 1, 1};

      repeat (2) @(negedge cpu_clk_i);
      chk("rst_cache_done", {31'd0, cache_done}, 32'd0);
      chk("rst_probe_valid", {31'd0, probe_valid_o}, 32'd0);
      chk("rst_dwr_en", {31'd0, dwr_en_o}, 32'd0);
      chk("rst_bus_req", {31'd0, bus.bus_req_o}, 32'd0);
      chk("rst_drain_idle", {31'd0, drain_idle_o}, 32'd1);
      chk("rst_counter", stores_drained_o, 32'd0);
      cpu_rst_i = 1'b0;
      @(negedge cpu_clk_i);

      for (int v = 0; v < 5; v++) begin
         ent[0] = vecs[v];
         run(1);
         cnt_exp++;
         chk($sformatf("v%0d_latency", v), done_cyc[0], vecs[v].lat);
         chk($sformatf("v%0d_probes", v), n_probe, vecs[v].probes);
         chk($sformatf("v%0d_dwr_writes", v), n_wr, vecs[v].writes);
         chk($sformatf("v%0d_bus_grants", v), n_gnt, 32'd1);
         chk($sformatf("v%0d_bus_fields", v), bad_bus, 32'd0);
         chk($sformatf("v%0d_dwr_fields", v), bad_dwr, 32'd0);
         chk($sformatf("v%0d_probe_addr", v), bad_probe, 32'd0);
         chk($sformatf("v%0d_idle_low", v), idle_busy, 32'd0);
         step();
         chk($sformatf("v%0d_idle_after", v), {31'd0, drain_idle_o}, 32'd1);
         chk($sformatf("v%0d_no_extra_done", v), n_done, 32'd1);
         chk($sformatf("v%0d_counter", v), stores_drained_o, cnt_exp);
      end

      // Three heads presented back to back: IO, cacheable miss, IO.
      ent[0] = '{1'b1, 30'h0000_0100, 32'h0000_0001, 4'hF, 1'b0, 2'd0, 0, 0, 16'h0000, 3, 0, 0};
      ent[1] = '{1'b0, 30'h0000_0200, 32'h0000_0002, 4'h1, 1'b0, 2'd0, 0, 0, 16'h0000, 5, 1, 0};
      ent[2] = '{1'b1, 30'h0000_0300, 32'h0000_0003, 4'h8, 1'b0, 2'd0, 0, 0, 16'h0000, 3, 0, 0};
      run(3);
      cnt_exp += 3;
      chk("b2b_done0", done_cyc[0], 32'd3);
      chk("b2b_done1", done_cyc[1], 32'd9);
      chk("b2b_done2", done_cyc[2], 32'd13);
      chk("b2b_grants", n_gnt, 32'd3);
      chk("b2b_addr0", {2'b00, gnt_addr[0]}, 32'h0000_0100);
      chk("b2b_addr1", {2'b00, gnt_addr[1]}, 32'h0000_0200);
      chk("b2b_addr2", {2'b00, gnt_addr[2]}, 32'h0000_0300);
      chk("b2b_bus_fields", bad_bus, 32'd0);
      chk("b2b_probes", n_probe, 32'd1);
      step();
      chk("b2b_counter", stores_drained_o, cnt_exp);

      // Reset lands while the fourth store waits for its bus ack.
      ent[0] = '{1'b1, 30'h0000_0400, 32'h0000_0004, 4'hF, 1'b0, 2'd0, 0, 20, 16'h0000, 0, 0, 0};
      start(1);
      repeat (3) step();
      chk("mid_bus_wait_busy", {31'd0, drain_idle_o}, 32'd0);
      cpu_rst_i = 1'b1; store_valid_i = 1'b0;
      bus.bus_gnt_i = 1'b0; bus.bus_ack_i = 1'b0;
      @(negedge cpu_clk_i);
      cpu_rst_i = 1'b0;
      chk("rst2_drain_idle", {31'd0, drain_idle_o}, 32'd1);
      chk("rst2_bus_req", {31'd0, bus.bus_req_o}, 32'd0);
      chk("rst2_counter", stores_drained_o, 32'd0);
      chk("rst2_cache_done", {31'd0, cache_done}, 32'd0);
      @(negedge cpu_clk_i);
      chk("rst2_still_idle", {31'd0, drain_idle_o}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
